// File: rtl/output_ctrl_vc2_if.sv
// Arbiter-side write ports, polarity and outbound link of one router output controller.
// master = router/arbiters/downstream side, slave = the output controller.
interface output_ctrl_vc2_if #(
   parameter int DATA_W = 64
) ();
   logic              polarity;
   logic              even_out_enable;
   logic [DATA_W-1:0] even_out_data;
   logic              odd_out_enable;
   logic [DATA_W-1:0] odd_out_data;
   logic              even_out_empty;
   logic              odd_out_empty;
   logic              so;
   logic [DATA_W-1:0] dout;
   logic              ri;
   logic              overflow_err;
   logic              vc_err;

   modport master (
      output polarity, even_out_enable, even_out_data, odd_out_enable, odd_out_data, ri,
      input  even_out_empty, odd_out_empty, so, dout, overflow_err, vc_err
   );

   modport slave (
      input  polarity, even_out_enable, even_out_data, odd_out_enable, odd_out_data, ri,
      output even_out_empty, odd_out_empty, so, dout, overflow_err, vc_err
   );
endinterface

// File: rtl/output_ctrl_vc2.sv
// Per-port output controller: two VC FIFOs written by the even/odd arbiters, drained
// alternately onto the outbound link according to polarity.
module output_ctrl_vc2 #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64
) (
   input logic              clk,
   input logic              reset,
   output_ctrl_vc2_if.slave bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_even [DEPTH];
   logic [DATA_W-1:0] mem_odd  [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_even, rd_ptr_even, wr_ptr_odd, rd_ptr_odd;
   logic [CNT_W-1:0]  count_even, count_odd;
   logic              so_q, overflow_q, vc_err_q;
   logic [DATA_W-1:0] dout_q;

   logic full_even, full_odd, req_even, req_odd;
   logic push_even, push_odd, pop_even, pop_odd, drop, vc_bad;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_even = (count_even == CNT_W'(DEPTH));
   assign full_odd  = (count_odd  == CNT_W'(DEPTH));

   // Polarity decides which arbiter may write and which VC may send; the two never coincide.
   assign req_even  = ~bus.polarity & bus.even_out_enable;
   assign req_odd   =  bus.polarity & bus.odd_out_enable;
   assign push_even = req_even & ~full_even;
   assign push_odd  = req_odd  & ~full_odd;
   assign drop      = (req_even & full_even) | (req_odd & full_odd);
   assign vc_bad    = (push_even &  bus.even_out_data[DATA_W-1])
                    | (push_odd  & ~bus.odd_out_data[DATA_W-1]);
   assign pop_even  =  bus.polarity & bus.ri & (count_even != '0);
   assign pop_odd   = ~bus.polarity & bus.ri & (count_odd  != '0);

   // NOTE: storage arrays carry no reset; the counts alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push_even) mem_even[wr_ptr_even] <= bus.even_out_data;
      if (push_odd)  mem_odd[wr_ptr_odd]   <= bus.odd_out_data;
   end

   // NOTE: all state updates use <= so every read above sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_even <= '0;
         rd_ptr_even <= '0;
         wr_ptr_odd  <= '0;
         rd_ptr_odd  <= '0;
         count_even  <= '0;
         count_odd   <= '0;
         so_q        <= 1'b0;
         dout_q      <= '0;
         overflow_q  <= 1'b0;
         vc_err_q    <= 1'b0;
      end else begin
         if (push_even) begin
            wr_ptr_even <= ptr_inc(wr_ptr_even);
            count_even  <= count_even + CNT_W'(1);
         end else if (pop_even) begin
            rd_ptr_even <= ptr_inc(rd_ptr_even);
            count_even  <= count_even - CNT_W'(1);
         end

         if (push_odd) begin
            wr_ptr_odd <= ptr_inc(wr_ptr_odd);
            count_odd  <= count_odd + CNT_W'(1);
         end else if (pop_odd) begin
            rd_ptr_odd <= ptr_inc(rd_ptr_odd);
            count_odd  <= count_odd - CNT_W'(1);
         end

         so_q <= pop_even | pop_odd;
         if (pop_even)     dout_q <= mem_even[rd_ptr_even];
         else if (pop_odd) dout_q <= mem_odd[rd_ptr_odd];

         if (drop)   overflow_q <= 1'b1;
         if (vc_bad) vc_err_q   <= 1'b1;
      end
   end

   assign bus.even_out_empty = ~full_even;
   assign bus.odd_out_empty  = ~full_odd;
   assign bus.so             = so_q;
   assign bus.dout           = dout_q;
   assign bus.overflow_err   = overflow_q;
   assign bus.vc_err         = vc_err_q;
endmodule
